// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding and constants for the pipeline hazard controller
package pipeline_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;
  localparam int DEF_REG_W = 5;
  localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with async reset that holds at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for load-use, taken branches and memory waits
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W    = DEF_REG_W,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             MemRead_EX,
  input  logic [REG_W-1:0] Rt_EX,
  input  logic [REG_W-1:0] Rs_ID,
  input  logic [REG_W-1:0] Rt_ID,
  input  logic             Uses_Rt_ID,
  input  logic             Branch_Taken_EX,
  input  logic             MemReq_MEM,
  input  logic             Mem_Ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Bubble,
  output logic             Mem_Timeout,
  output logic [CNT_W-1:0] Stall_Cycles,
  output logic [CNT_W-1:0] Flush_Events
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_base, wait_nxt;
  logic freeze, load_use, br, lu;
  assign freeze   = MemReq_MEM & ~Mem_Ready;
  assign load_use = MemRead_EX & (|Rt_EX) & ((Rt_EX == Rs_ID) | (Uses_Rt_ID & (Rt_EX == Rt_ID)));
  assign br = ~freeze & Branch_Taken_EX;
  assign lu = ~freeze & ~Branch_Taken_EX & load_use;
  assign wait_base = (state == MEM_WAIT) ? wait_cnt : '0;
  assign wait_nxt  = !freeze ? '0 : (wait_base == CNT_W'(MAX_WAIT)) ? wait_base : wait_base + 1'b1;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      Mem_Timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      Mem_Timeout <= Mem_Timeout | (wait_nxt == CNT_W'(MAX_WAIT));
    end
  // A freeze holds every stage; the ID/EX bubble load still needs its write enable.
  always_comb begin
    state_nxt     = freeze ? MEM_WAIT : RUN;
    PC_Write      = ~freeze & ~lu;
    IF_ID_Write   = ~freeze & ~lu;
    IF_ID_Flush   = br;
    ID_EX_Write   = ~freeze;
    ID_EX_Flush   = br | lu;
    EX_MEM_Write  = ~freeze;
    MEM_WB_Bubble = freeze;
  end
  sat_counter #(.W(CNT_W)) u_stall (.clk(Clk), .rst(Reset), .inc(~PC_Write), .count(Stall_Cycles));
  sat_counter #(.W(CNT_W)) u_flush (.clk(Clk), .rst(Reset), .inc(br), .count(Flush_Events));
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed and random checks against a rule-level model
module tb_pipeline_hazard_controller;
  localparam int REG_W = 5, CNT_W = 6, MAX_WAIT = 5;
  localparam int SAT = (1 << CNT_W) - 1;
  logic Clk = 0, Reset = 1;
  logic MemRead_EX = 0, Uses_Rt_ID = 0, Branch_Taken_EX = 0, MemReq_MEM = 0, Mem_Ready = 0;
  logic [REG_W-1:0] Rt_EX = 0, Rs_ID = 0, Rt_ID = 0;
  logic PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, MEM_WB_Bubble, Mem_Timeout;
  logic [CNT_W-1:0] Stall_Cycles, Flush_Events;
  int n_cmp = 0, n_bad = 0;

  pipeline_hazard_controller #(.REG_W(REG_W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .Clk(Clk), .Reset(Reset), .MemRead_EX(MemRead_EX), .Rt_EX(Rt_EX), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .Uses_Rt_ID(Uses_Rt_ID), .Branch_Taken_EX(Branch_Taken_EX), .MemReq_MEM(MemReq_MEM), .Mem_Ready(Mem_Ready),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush), .ID_EX_Write(ID_EX_Write),
    .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Write(EX_MEM_Write), .MEM_WB_Bubble(MEM_WB_Bubble),
    .Mem_Timeout(Mem_Timeout), .Stall_Cycles(Stall_Cycles), .Flush_Events(Flush_Events));

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: consecutive freeze cycles, raw event totals, sticky timeout
  int m_consec = 0, m_stall = 0, m_flush = 0;
  bit m_to = 0;

  always @(negedge Clk) begin
    bit f, l, e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_bub;
    f = MemReq_MEM && !Mem_Ready;
    l = MemRead_EX && Rt_EX != 0 && (Rt_EX == Rs_ID || (Uses_Rt_ID && Rt_EX == Rt_ID));
    if (f)                    {e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_bub} = 7'b0000001;
    else if (Branch_Taken_EX) {e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_bub} = 7'b1111110;
    else if (l)               {e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_bub} = 7'b0001110;
    else                      {e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_bub} = 7'b1101010;
    if (Reset) begin
      m_consec = 0; m_stall = 0; m_flush = 0; m_to = 0;
    end
    chk("PC_Write", PC_Write, e_pc);
    chk("IF_ID_Write", IF_ID_Write, e_ifw);
    chk("IF_ID_Flush", IF_ID_Flush, e_iff);
    chk("ID_EX_Write", ID_EX_Write, e_idw);
    chk("ID_EX_Flush", ID_EX_Flush, e_idf);
    chk("EX_MEM_Write", EX_MEM_Write, e_exw);
    chk("MEM_WB_Bubble", MEM_WB_Bubble, e_bub);
    chk("Mem_Timeout", Mem_Timeout, m_to);
    chk("Stall_Cycles", Stall_Cycles, m_stall > SAT ? SAT : m_stall);
    chk("Flush_Events", Flush_Events, m_flush > SAT ? SAT : m_flush);
    if (!Reset) begin
      m_consec = f ? m_consec + 1 : 0;
      if (m_consec >= MAX_WAIT) m_to = 1;
      if (!e_pc) m_stall++;
      if (!f && Branch_Taken_EX) m_flush++;
    end
  end

  task automatic drive(input bit mr, input int rte, input int rs, input int rt, input bit urt,
                       input bit br, input bit req, input bit rdy);
    @(posedge Clk);
    #2;
    MemRead_EX = mr; Rt_EX = REG_W'(rte); Rs_ID = REG_W'(rs); Rt_ID = REG_W'(rt);
    Uses_Rt_ID = urt; Branch_Taken_EX = br; MemReq_MEM = req; Mem_Ready = rdy;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_pulse();
    @(posedge Clk);
    #3 Reset = 1;
    @(posedge Clk);
    #2 Reset = 0;
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #2 Reset = 0;
    // Reset mid-freeze
    repeat (3) drive(0, 0, 0, 0, 0, 0, 1, 0);
    #1 Reset = 1;
    #1 chk("rst_stall", Stall_Cycles, 0);
    chk("rst_timeout", Mem_Timeout, 0);
    idle();
    Reset = 0;
    #1 chk("rst_pc_write", PC_Write, 1);
    chk("rst_stall_after", Stall_Cycles, 0);
    // Load-use, then load to $zero
    drive(1, 8, 8, 0, 0, 0, 0, 0);
    chk("lu_pc", PC_Write, 0);
    chk("lu_ifid", IF_ID_Write, 0);
    chk("lu_idex_flush", ID_EX_Flush, 1);
    idle();
    chk("lu_release", PC_Write, 1);
    chk("lu_stall_cnt", Stall_Cycles, 1);
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    chk("zero_pc", PC_Write, 1);
    idle();
    chk("zero_stall_cnt", Stall_Cycles, 1);
    // Branch beats load-use
    drive(1, 8, 3, 8, 1, 1, 0, 0);
    chk("br_iff", IF_ID_Flush, 1);
    chk("br_idf", ID_EX_Flush, 1);
    chk("br_pc", PC_Write, 1);
    idle();
    chk("br_flush_cnt", Flush_Events, 1);
    chk("br_stall_cnt", Stall_Cycles, 1);
    // Four-cycle wait below the timeout
    repeat (4) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      chk("wait_bubble", MEM_WB_Bubble, 1);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    chk("wait_release_pc", PC_Write, 1);
    idle();
    chk("wait_stall_cnt", Stall_Cycles, 5);
    chk("wait_no_timeout", Mem_Timeout, 0);
    // Six-cycle wait crosses MAX_WAIT on its fifth cycle
    for (int i = 1; i <= 6; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      chk("to_progress", Mem_Timeout, i >= 6 ? 1 : 0);
    end
    idle();
    chk("to_sticky", Mem_Timeout, 1);
    chk("to_stall_cnt", Stall_Cycles, 11);
    reset_pulse();
    #1 chk("to_cleared", Mem_Timeout, 0);
    // Branch held through a two-cycle wait
    repeat (2) begin
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      chk("hold_no_flush", IF_ID_Flush, 0);
    end
    drive(0, 0, 0, 0, 0, 1, 1, 1);
    chk("hold_iff", IF_ID_Flush, 1);
    chk("hold_idf", ID_EX_Flush, 1);
    idle();
    chk("hold_flush_cnt", Flush_Events, 1);
    chk("hold_stall_cnt", Stall_Cycles, 2);
    // Random traffic with occasional resets and long waits to reach saturation
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) reset_pulse();
      drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) == 0);
    end
    idle();
    @(negedge Clk);
    #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
